// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG collector slice.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COLLECT
    } trng_state_t;

    localparam int TRNG_WORD_W     = 32;
    localparam int TRNG_FIFO_DEPTH = 4;
    localparam int TRNG_WARMUP     = 64;

endpackage

// File: rtl/trng_collector_if.sv
// Valid/ready read port carrying packed random words to the SoC wrapper.
interface trng_collector_if #(
    parameter int WIDTH = 32
);
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/trng_word_fifo.sv
// Synchronous first-word-fall-through word FIFO; a pop frees space for a push in the same cycle.
module trng_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign rd_valid = (level != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign do_pop   = pop && rd_valid;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // When full, wr_ptr equals rd_ptr: the head is read before this edge overwrites it.
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/trng_collector.sv
// Ring-oscillator TRNG collector: warm-up, bit packing (MSB first) and word buffering.
// Optional von Neumann debiasing is built in when TRNG_VN_DEBIAS_EN is defined.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WIDTH         = TRNG_WORD_W,
    parameter int DEPTH         = TRNG_FIFO_DEPTH,
    parameter int WARMUP_CYCLES = TRNG_WARMUP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    output logic                       trng_en,
    input  logic                       trng_bit,
    trng_collector_if.master           rd,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overrun,
    input  logic                       overrun_clr
);
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    trng_state_t       state;
    trng_state_t       next_state;
    logic [WCNT_W-1:0] warm_cnt;
    logic              warm_done;
    logic [1:0]        sync_q;
    logic              sbit;
    logic              collecting;
    logic              acc_valid;
    logic              acc_bit;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done;
    logic [WIDTH-1:0]  push_word;
    logic              fifo_full;
    logic              fifo_valid;
    logic [WIDTH-1:0]  fifo_data;
    logic              pop;
    logic              drop;

    assign sbit       = sync_q[1];
    assign collecting = (state == ST_COLLECT);
    assign warm_done  = (warm_cnt == WCNT_W'(WARMUP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], trng_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable) next_state = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (!enable)        next_state = ST_IDLE;
                else if (warm_done) next_state = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (!enable) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Counter idles at zero outside WARMUP so every entry restarts the full warm-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= '0;
        end else if (state == ST_WARMUP) begin
            warm_cnt <= warm_cnt + WCNT_W'(1);
        end else begin
            warm_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trng_en <= 1'b0;
        end else begin
            trng_en <= (state != ST_IDLE);
        end
    end

`ifdef TRNG_VN_DEBIAS_EN
    logic pair_phase;
    logic pair_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_phase <= 1'b0;
            pair_a     <= 1'b0;
        end else if (!collecting) begin
            pair_phase <= 1'b0;
            pair_a     <= 1'b0;
        end else begin
            if (!pair_phase) pair_a <= sbit;
            pair_phase <= ~pair_phase;
        end
    end

    always_comb begin
        acc_valid = collecting && pair_phase && (pair_a != sbit);
        acc_bit   = pair_a;
    end
`else
    always_comb begin
        acc_valid = collecting;
        acc_bit   = sbit;
    end
`endif

    assign word_done = acc_valid && (bit_cnt == CNT_W'(WIDTH - 1));
    assign push_word = {shreg[WIDTH-2:0], acc_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (!collecting) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (acc_valid) begin
            shreg   <= push_word;
            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    assign pop  = fifo_valid && rd.rd_ready;
    assign drop = word_done && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    trng_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (word_done),
        .push_data (push_word),
        .pop       (pop),
        .full      (fifo_full),
        .level     (fifo_level),
        .rd_valid  (fifo_valid),
        .rd_data   (fifo_data)
    );

    assign rd.rd_valid = fifo_valid;
    assign rd.rd_data  = fifo_data;

endmodule
